// File: rtl/commit_sequencer.sv
// commit_sequencer
//   In-order commit buffer. Issue allocates a tag at the tail. Execution
//   units write results back by tag. The head entry retires once it is DONE.
//   A retiring branch whose resolved direction differs from its prediction
//   flushes every entry and redirects fetch.
//
// Entry states:
//   state    | meaning
//   ---------+-------------------------------------------------
//   E_FREE   | slot unoccupied
//   E_ISSUED | allocated, waiting for its writeback
//   E_DONE   | result captured, eligible to commit at the head
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (pause when low)
//   alloc_*        : allocation request from issue; alloc_ready/alloc_tag back
//   wb_*           : result broadcast from execution units
//   rob_commit_signal, commit_rd_* : register-file commit port (1-cycle pulse)
//   clear_signal, redirect_pc      : mispredict flush and fetch redirect
//   count          : number of occupied entries
module commit_sequencer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 alloc_valid,
  input  logic [4:0]           alloc_rd_id,
  input  logic                 alloc_is_branch,
  input  logic                 alloc_pred_taken,
  output logic                 alloc_ready,
  output logic [ROB_WIDTH-1:0] alloc_tag,
  input  logic                 wb_valid,
  input  logic [ROB_WIDTH-1:0] wb_tag,
  input  logic [31:0]          wb_value,
  input  logic                 wb_taken,
  input  logic [31:0]          wb_target,
  output logic                 rob_commit_signal,
  output logic [31:0]          commit_rd_value,
  output logic [4:0]           commit_rd_id,
  output logic [ROB_WIDTH-1:0] commit_rd_tag,
  output logic                 clear_signal,
  output logic [31:0]          redirect_pc,
  output logic [ROB_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL_CNT = {1'b1, {ROB_WIDTH{1'b0}}};
  localparam logic [ROB_WIDTH:0] CNT_ONE  = {{ROB_WIDTH{1'b0}}, 1'b1};
  localparam logic [ROB_WIDTH-1:0] PTR_ONE = {{(ROB_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    E_FREE   = 2'd0,
    E_ISSUED = 2'd1,
    E_DONE   = 2'd2
  } entry_state_t;

  entry_state_t        ent_state      [DEPTH];
  logic [4:0]          ent_rd_id      [DEPTH];
  logic                ent_is_branch  [DEPTH];
  logic                ent_pred_taken [DEPTH];
  logic [31:0]         ent_value      [DEPTH];
  logic                ent_taken      [DEPTH];
  logic [31:0]         ent_target     [DEPTH];

  logic [ROB_WIDTH-1:0] head;
  logic [ROB_WIDTH-1:0] tail;

  logic head_done;
  logic flush_now;
  logic do_commit;
  logic do_flush;
  logic do_alloc;
  logic do_wb;

  always_comb begin
    head_done   = (ent_state[head] == E_DONE);
    flush_now   = head_done & ent_is_branch[head] &
                  (ent_taken[head] != ent_pred_taken[head]);
    alloc_ready = (count != FULL_CNT) & ~clear_signal & ~flush_now;
    alloc_tag   = tail;
    do_commit   = rdy_in & head_done;
    do_flush    = do_commit & flush_now;
    // alloc_ready already excludes flush_now, so an allocation never
    // coincides with a flush.
    do_alloc    = rdy_in & alloc_valid & alloc_ready;
    // Judged on pre-edge state: a tag allocated this same edge is still FREE
    // and its writeback is dropped; the committing head is DONE, so it is
    // never rewritten either.
    do_wb       = rdy_in & wb_valid & (ent_state[wb_tag] == E_ISSUED) & ~do_flush;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) ent_state[i] <= E_FREE;
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      rob_commit_signal <= 1'b0;
      clear_signal      <= 1'b0;
      commit_rd_value   <= '0;
      commit_rd_id      <= '0;
      commit_rd_tag     <= '0;
      redirect_pc       <= '0;
    end else begin
      rob_commit_signal <= do_commit;
      clear_signal      <= do_flush;
      if (do_commit) begin
        commit_rd_value <= ent_value[head];
        commit_rd_id    <= ent_rd_id[head];
        commit_rd_tag   <= head;
      end
      if (do_flush) begin
        redirect_pc <= ent_target[head];
        for (int i = 0; i < DEPTH; i++) ent_state[i] <= E_FREE;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_wb) ent_state[wb_tag] <= E_DONE;
        if (do_commit) begin
          ent_state[head] <= E_FREE;
          head            <= head + PTR_ONE;
        end
        if (do_alloc) begin
          ent_state[tail] <= E_ISSUED;
          tail            <= tail + PTR_ONE;
        end
        case ({do_alloc, do_commit})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // Payload fields are only meaningful while the slot is ISSUED/DONE,
  // so they need no reset.
  always_ff @(posedge clk_in) begin
    if (do_alloc) begin
      ent_rd_id[tail]      <= alloc_rd_id;
      ent_is_branch[tail]  <= alloc_is_branch;
      ent_pred_taken[tail] <= alloc_pred_taken;
    end
    if (do_wb) begin
      ent_value[wb_tag]  <= wb_value;
      ent_taken[wb_tag]  <= wb_taken;
      ent_target[wb_tag] <= wb_target;
    end
  end

endmodule
